// File: rtl/tft_pkg.sv
// Shared timing defaults, FSM state type and pixel width for the TFT frame reader.
package tft_pkg;

  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;
  localparam int DEF_IMG_W    = 256;
  localparam int DEF_IMG_H    = 256;
  localparam int DEF_X_OFF    = 112;
  localparam int DEF_Y_OFF    = 8;

  function automatic int line_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  localparam int H_TOTAL      = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL      = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  localparam int RGB_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } fsm_e;

endpackage

// File: rtl/tft_frame_reader_if.sv
// Frame-buffer port-B bus: the reader is the master, the BRAM is the slave.
interface tft_frame_reader_if #(
  parameter int ADDR_W = 18
);
  logic              enb_o;
  logic [ADDR_W-1:0] addrb_o;
  logic [7:0]        mem2db_i;

  modport master (output enb_o, output addrb_o, input mem2db_i);
  modport slave  (input enb_o, input addrb_o, output mem2db_i);
endinterface

// File: rtl/tft_timing_gen.sv
// Raster counters plus sync, active, image-window and frame-done flags, all in counter time.
// With BORDER_EN defined an extra flag marks the outermost image rows and columns.
module tft_timing_gen
  import tft_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int X_OFF    = DEF_X_OFF,
  parameter int Y_OFF    = DEF_Y_OFF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic active,
  output logic win,
`ifdef BORDER_EN
  output logic border,
`endif
  output logic hsync_n,
  output logic vsync_n,
  output logic frame_start,
  output logic frame_end,
  output logic frame_done
);

  localparam int H_TOT = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] X_LO   = HW'(X_OFF);
  localparam logic [HW-1:0] X_HI   = HW'(X_OFF + IMG_W - 1);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_LO      = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI      = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] Y_LO       = VW'(Y_OFF);
  localparam logic [VW-1:0] Y_HI       = VW'(Y_OFF + IMG_H - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          in_x;
  logic          in_y;
  logic          h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  // Counters sit at 0 while idle so the first active clock is always h=v=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= run && h_wrap && (v_cnt == V_ACT_LAST);
  end

  assign in_x        = (h_cnt >= X_LO) && (h_cnt <= X_HI);
  assign in_y        = (v_cnt >= Y_LO) && (v_cnt <= Y_HI);
  assign active      = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign win         = run && in_x && in_y;
  assign hsync_n     = !(run && (h_cnt >= HS_LO) && (h_cnt <= HS_HI));
  assign vsync_n     = !(run && (v_cnt >= VS_LO) && (v_cnt <= VS_HI));
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign frame_end   = h_wrap && (v_cnt == V_LAST);

`ifdef BORDER_EN
  assign border = win && ((h_cnt == X_LO) || (h_cnt == X_HI) ||
                          (v_cnt == Y_LO) || (v_cnt == Y_HI));
`endif

endmodule

// File: rtl/tft_frame_reader.sv
// Port-B frame-buffer reader: drives 480x272 TFT timing and grayscale-to-RGB pixels.
// Optional macro BORDER_EN paints the outermost image rows/columns white.
module tft_frame_reader
  import tft_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int RD_LAT   = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int X_OFF    = DEF_X_OFF,
  parameter int Y_OFF    = DEF_Y_OFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bram_en_i,
  tft_frame_reader_if.master   bram,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output logic [RGB_W-1:0]     rgb_o,
  output logic                 frame_done_o,
  output logic                 busy_o
);

  localparam int DLY = RD_LAT + 1;

  fsm_e              state_q;
  logic              run;
  logic              active;
  logic              win;
  logic              hsync_n;
  logic              vsync_n;
  logic              frame_start;
  logic              frame_end;
  logic              frame_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DLY-1:0]    hs_d;
  logic [DLY-1:0]    vs_d;
  logic [DLY-1:0]    de_d;
  logic [RD_LAT-1:0] win_d;
  logic [RGB_W-1:0]  rgb_q;
`ifdef BORDER_EN
  logic              border;
  logic [RD_LAT-1:0] border_d;
`endif

  assign run = (state_q != IDLE);

  tft_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .IMG_W    (IMG_W),    .IMG_H (IMG_H), .X_OFF (X_OFF), .Y_OFF (Y_OFF)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .active      (active),
    .win         (win),
`ifdef BORDER_EN
    .border      (border),
`endif
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_done  (frame_done)
  );

  // Dropping the enable only takes effect at the end of the frame being scanned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bram_en_i) state_q <= ACTIVE;
        ACTIVE:  if (!bram_en_i) state_q <= frame_end ? IDLE : DRAIN;
        DRAIN: begin
          if (bram_en_i)      state_q <= ACTIVE;
          else if (frame_end) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      addr_q <= '0;
    else if (!run || frame_start) addr_q <= '0;
    else if (win)                 addr_q <= addr_q + ADDR_W'(1);
  end

  assign bram.enb_o   = win;
  assign bram.addrb_o = win ? addr_q : '0;

  // Syncs and de travel RD_LAT+1 stages; the window flag only RD_LAT, since rgb adds a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d     <= '1;
      vs_d     <= '1;
      de_d     <= '0;
      win_d    <= '0;
`ifdef BORDER_EN
      border_d <= '0;
`endif
    end else begin
      hs_d     <= DLY'({hs_d, hsync_n});
      vs_d     <= DLY'({vs_d, vsync_n});
      de_d     <= DLY'({de_d, active});
      win_d    <= RD_LAT'({win_d, win});
`ifdef BORDER_EN
      border_d <= RD_LAT'({border_d, border});
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (win_d[RD_LAT-1]) begin
`ifdef BORDER_EN
      rgb_q <= border_d[RD_LAT-1] ? {RGB_W{1'b1}} : {3{bram.mem2db_i}};
`else
      rgb_q <= {3{bram.mem2db_i}};
`endif
    end else begin
      rgb_q <= '0;
    end
  end

  assign hsync_o      = hs_d[DLY-1];
  assign vsync_o      = vs_d[DLY-1];
  assign de_o         = de_d[DLY-1];
  assign rgb_o        = rgb_q;
  assign frame_done_o = frame_done;
  assign busy_o       = run;

endmodule

// File: tb/tb_tft_frame_reader.sv
// Directed bench: full-size reader for pixel/address checks, shrunken reader for frame-level checks.
module tb_tft_frame_reader;

  logic        clk;
  logic        rst_a, en_a, rst_b, en_b;
  logic        hs_a, vs_a, de_a, fd_a, busy_a;
  logic        hs_b, vs_b, de_b, fd_b, busy_b;
  logic [23:0] rgb_a, rgb_b;
  logic [7:0]  mem [0:65535];
  logic [7:0]  stage_b;
  logic        prev_hs, prev_vs;
  int          compared, mismatched;
  int          de_cnt, hs_low, hs_falls, vs_low, vs_falls, fd_cnt, fd_first, fd_second;

  tft_frame_reader_if #(.ADDR_W(18)) bus_a ();
  tft_frame_reader_if #(.ADDR_W(18)) bus_b ();

  tft_frame_reader dut (
    .clk(clk), .rst(rst_a), .bram_en_i(en_a), .bram(bus_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a), .rgb_o(rgb_a),
    .frame_done_o(fd_a), .busy_o(busy_a)
  );

  // 27x17 raster, 8x6 image at (5,3), two-clock BRAM
  tft_frame_reader #(
    .ADDR_W(18), .RD_LAT(2),
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .IMG_W(8), .IMG_H(6), .X_OFF(5), .Y_OFF(3)
  ) mini (
    .clk(clk), .rst(rst_b), .bram_en_i(en_b), .bram(bus_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b), .rgb_o(rgb_b),
    .frame_done_o(fd_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus_a.enb_o) bus_a.mem2db_i <= mem[bus_a.addrb_o[15:0]];

  always @(posedge clk) begin
    if (bus_b.enb_o) stage_b <= mem[bus_b.addrb_o[15:0]];
    bus_b.mem2db_i <= stage_b;
  end

  function automatic logic [31:0] edge_px(input logic [31:0] px);
`ifdef BORDER_EN
    return 32'hFFFFFF;
`else
    return px;
`endif
  endfunction

  task automatic applyStimulus(input logic ra, input logic ea, input logic rb, input logic eb);
    rst_a = ra;
    en_a  = ea;
    rst_b = rb;
    en_b  = eb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);

    checkOutput("rst_enb",   32'(bus_a.enb_o), 0);
    checkOutput("rst_addr",  32'(bus_a.addrb_o), 0);
    checkOutput("rst_hsync", 32'(hs_a), 1);
    checkOutput("rst_vsync", 32'(vs_a), 1);
    checkOutput("rst_de",    32'(de_a), 0);
    checkOutput("rst_rgb",   32'(rgb_a), 0);
    checkOutput("rst_fdone", 32'(fd_a), 0);
    checkOutput("rst_busy",  32'(busy_a), 0);
    checkOutput("mini_rst_hsync", 32'(hs_b), 1);
    checkOutput("mini_rst_busy",  32'(busy_b), 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n <= 26450; n++) begin
      @(negedge clk);
      case (n)
        0: begin
          checkOutput("busy_entry", 32'(busy_a), 1);
          checkOutput("de_entry", 32'(de_a), 0);
          checkOutput("enb_entry", 32'(bus_a.enb_o), 0);
          checkOutput("mini_idle_busy", 32'(busy_b), 0);
          checkOutput("mini_idle_hsync", 32'(hs_b), 1);
        end
        1:     checkOutput("de_n1", 32'(de_a), 0);
        2:     checkOutput("de_rise", 32'(de_a), 1);
        481:   checkOutput("de_last_col", 32'(de_a), 1);
        482:   checkOutput("de_fp", 32'(de_a), 0);
        483:   checkOutput("hsync_pre", 32'(hs_a), 1);
        484:   checkOutput("hsync_fall", 32'(hs_a), 0);
        524:   checkOutput("hsync_end", 32'(hs_a), 0);
        525:   checkOutput("hsync_rise", 32'(hs_a), 1);
        4311:  checkOutput("enb_pre_win", 32'(bus_a.enb_o), 0);
        4312: begin
          checkOutput("enb_first", 32'(bus_a.enb_o), 1);
          checkOutput("addr_first", 32'(bus_a.addrb_o), 0);
        end
        4313: begin
          checkOutput("addr_second", 32'(bus_a.addrb_o), 1);
          checkOutput("rgb_pre_win", 32'(rgb_a), 0);
          checkOutput("de_pre_win", 32'(de_a), 1);
        end
        4314:  checkOutput("rgb_first", 32'(rgb_a), edge_px(32'h000000));
        4315:  checkOutput("rgb_second", 32'(rgb_a), edge_px(32'h010101));
        4837:  checkOutput("addr_row9", 32'(bus_a.addrb_o), 256);
        4839:  checkOutput("rgb_row9_col0", 32'(rgb_a), edge_px(32'h000000));
        4840:  checkOutput("rgb_row9_col1", 32'(rgb_a), 32'h010101);
        5093:  checkOutput("rgb_row9_col254", 32'(rgb_a), 32'hFEFEFE);
        5095: begin
          checkOutput("rgb_post_win", 32'(rgb_a), 0);
          checkOutput("de_post_win", 32'(de_a), 1);
        end
        25925: begin
          checkOutput("addr_v49", 32'(bus_a.addrb_o), 10584);
          checkOutput("enb_v49", 32'(bus_a.enb_o), 1);
        end
        25927: checkOutput("rgb_v49", 32'(rgb_a), 32'h585858);
        26000: checkOutput("vsync_mid", 32'(vs_a), 1);
        26450: begin
          checkOutput("addr_v50", 32'(bus_a.addrb_o), 10840);
          checkOutput("enb_v50", 32'(bus_a.enb_o), 1);
          checkOutput("rgb_v50", 32'(rgb_a), 32'h565656);
        end
        default: ;
      endcase
    end

    #2;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("async_enb",   32'(bus_a.enb_o), 0);
    checkOutput("async_addr",  32'(bus_a.addrb_o), 0);
    checkOutput("async_de",    32'(de_a), 0);
    checkOutput("async_rgb",   32'(rgb_a), 0);
    checkOutput("async_busy",  32'(busy_a), 0);
    checkOutput("async_hsync", 32'(hs_a), 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n <= 4313; n++) begin
      @(negedge clk);
      case (n)
        0:    checkOutput("re_busy", 32'(busy_a), 1);
        4312: begin
          checkOutput("re_addr_first", 32'(bus_a.addrb_o), 0);
          checkOutput("re_enb_first", 32'(bus_a.enb_o), 1);
        end
        4313: checkOutput("re_addr_second", 32'(bus_a.addrb_o), 1);
        default: ;
      endcase
    end

    de_cnt = 0; hs_low = 0; hs_falls = 0; vs_low = 0; vs_falls = 0;
    fd_cnt = 0; fd_first = -1; fd_second = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n <= 930; n++) begin
      @(negedge clk);
      if (n >= 3 && n < 462) begin
        if (de_b) de_cnt++;
        if (!hs_b) hs_low++;
        if (!vs_b) vs_low++;
        if (prev_hs && !hs_b) hs_falls++;
        if (prev_vs && !vs_b) vs_falls++;
      end
      if (fd_b) begin
        if (n < 459) fd_cnt++;
        if (fd_first < 0) fd_first = n;
        else if (fd_second < 0) fd_second = n;
      end
      prev_hs = hs_b;
      prev_vs = vs_b;
      case (n)
        0:   checkOutput("mini_busy_entry", 32'(busy_b), 1);
        2:   checkOutput("mini_de_n2", 32'(de_b), 0);
        3:   checkOutput("mini_de_rise", 32'(de_b), 1);
        86: begin
          checkOutput("mini_enb_first", 32'(bus_b.enb_o), 1);
          checkOutput("mini_addr_first", 32'(bus_b.addrb_o), 0);
        end
        89:  checkOutput("mini_rgb_first", 32'(rgb_b), edge_px(32'h000000));
        90:  checkOutput("mini_rgb_second", 32'(rgb_b), edge_px(32'h010101));
        114: checkOutput("mini_addr_interior", 32'(bus_b.addrb_o), 9);
        117: checkOutput("mini_rgb_interior", 32'(rgb_b), 32'h090909);
        228: begin
          checkOutput("mini_addr_last", 32'(bus_b.addrb_o), 47);
          checkOutput("mini_enb_last", 32'(bus_b.enb_o), 1);
        end
        229: begin
          checkOutput("mini_enb_after", 32'(bus_b.enb_o), 0);
          checkOutput("mini_addr_after", 32'(bus_b.addrb_o), 0);
        end
        231: checkOutput("mini_rgb_last", 32'(rgb_b), edge_px(32'h2F2F2F));
        687: begin
          checkOutput("drain_addr_last", 32'(bus_b.addrb_o), 47);
          checkOutput("drain_enb_last", 32'(bus_b.enb_o), 1);
        end
        917: checkOutput("drain_busy_end", 32'(busy_b), 1);
        918: checkOutput("drain_idle", 32'(busy_b), 0);
        925: begin
          checkOutput("idle_hsync", 32'(hs_b), 1);
          checkOutput("idle_vsync", 32'(vs_b), 1);
          checkOutput("idle_enb", 32'(bus_b.enb_o), 0);
          checkOutput("idle_de", 32'(de_b), 0);
        end
        default: ;
      endcase
      if (n == 594) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end

    checkOutput("mini_de_count",   32'(de_cnt), 240);
    checkOutput("mini_hs_low",     32'(hs_low), 51);
    checkOutput("mini_hs_pulses",  32'(hs_falls), 17);
    checkOutput("mini_vs_low",     32'(vs_low), 54);
    checkOutput("mini_vs_pulses",  32'(vs_falls), 1);
    checkOutput("mini_fd_count",   32'(fd_cnt), 1);
    checkOutput("mini_fd_first",   32'(fd_first), 324);
    checkOutput("mini_fd_spacing", 32'(fd_second - fd_first), 459);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
